// File: rtl/key_cmd_if.sv
// Keyboard-event / game-command bus between the PS/2 reader side and the command scheduler.
// The master drives key events and acks; the slave (scheduler) returns the queued commands.
interface key_cmd_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [7:0]    ascii;
  logic          key_break;
  logic          ready;
  logic          enable;
  logic          flush;
  logic          cmd_ack;
  logic          cmd_valid;
  logic [2:0]    cmd;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output ascii, key_break, ready, enable, flush, cmd_ack,
    input  cmd_valid, cmd, count, overflow
  );

  modport slave (
    input  ascii, key_break, ready, enable, flush, cmd_ack,
    output cmd_valid, cmd, count, overflow
  );
endinterface

// File: rtl/key_cmd_scheduler.sv
// Turns PS/2 key events into a FIFO of 3-bit PushBox commands.
// It case-folds keys, suppresses typematic repeats, and is drained by a valid/ack handshake.
module key_cmd_scheduler #(
  parameter int unsigned DEPTH = 4
) (
  input logic     clk,
  input logic     rst,
  key_cmd_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          ready_q;
  logic          ready_hold;
  logic          ev_valid;
  logic          ev_break;
  logic [7:0]    ev_ascii;
  logic          held_valid;
  logic [7:0]    held_ascii;
  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          cmd_valid_q;
  logic [2:0]    cmd_q;
  logic          overflow_q;

  logic          event_c;
  logic [7:0]    fold_c;
  logic          map_hit_c;
  logic [2:0]    map_cmd_c;
  logic          is_repeat_c;
  logic          push_req_c;
  logic          pop_c;
  logic          full_c;
  logic          push_c;
  logic          drop_c;
  logic [AW-1:0] rd_next_c;
  logic [CW-1:0] cnt_next_c;
  logic [2:0]    head_next_c;

  // ready_hold masks a ready level that was already high when reset was released
  assign event_c = bus.ready & ~ready_q & ~ready_hold;
  assign fold_c  = (bus.ascii >= 8'h41 && bus.ascii <= 8'h5A) ? bus.ascii + 8'h20 : bus.ascii;

  always_comb begin
    map_hit_c = 1'b1;
    map_cmd_c = 3'd0;
    case (ev_ascii)
      8'h77:   map_cmd_c = 3'd0;   // w
      8'h73:   map_cmd_c = 3'd1;   // s
      8'h61:   map_cmd_c = 3'd2;   // a
      8'h64:   map_cmd_c = 3'd3;   // d
      8'h75:   map_cmd_c = 3'd4;   // u
      8'h72:   map_cmd_c = 3'd5;   // r
      8'h6E:   map_cmd_c = 3'd6;   // n
      8'h70:   map_cmd_c = 3'd7;   // p
      default: map_hit_c = 1'b0;
    endcase
  end

  always_comb begin
    is_repeat_c = held_valid && (ev_ascii == held_ascii);
    push_req_c  = ev_valid & ~ev_break & ~is_repeat_c & map_hit_c & bus.enable;
    pop_c       = (cnt != '0) & bus.cmd_ack;
    full_c      = (cnt == CW'(DEPTH));
    push_c      = push_req_c & (~full_c | pop_c);
    drop_c      = push_req_c & full_c & ~pop_c;
    rd_next_c   = pop_c ? rd_ptr + AW'(1) : rd_ptr;
    cnt_next_c  = cnt + CW'(push_c) - CW'(pop_c);
    // A push into a queue that is (or becomes) empty bypasses memory onto the head
    head_next_c = (push_c && (cnt - CW'(pop_c)) == '0) ? map_cmd_c : mem[rd_next_c];
  end

  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && push_c) mem[wr_ptr] <= map_cmd_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q     <= 1'b0;
      ready_hold  <= bus.ready;
      ev_valid    <= 1'b0;
      ev_break    <= 1'b0;
      ev_ascii    <= 8'h00;
      held_valid  <= 1'b0;
      held_ascii  <= 8'h00;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      cnt         <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= 3'd0;
      overflow_q  <= 1'b0;
    end else begin
      ready_q    <= bus.ready;
      ready_hold <= ready_hold & bus.ready;
      if (bus.flush) begin
        ev_valid    <= 1'b0;
        ev_break    <= 1'b0;
        ev_ascii    <= 8'h00;
        held_valid  <= 1'b0;
        rd_ptr      <= '0;
        wr_ptr      <= '0;
        cnt         <= '0;
        cmd_valid_q <= 1'b0;
        cmd_q       <= 3'd0;
      end else begin
        ev_valid <= event_c;
        if (event_c) begin
          ev_ascii <= fold_c;
          ev_break <= bus.key_break;
        end
        // Held-key tracking: breaks release the held key, new makes replace it
        if (ev_valid) begin
          if (ev_break) begin
            if (is_repeat_c) held_valid <= 1'b0;
          end else if (!is_repeat_c) begin
            held_ascii <= ev_ascii;
            held_valid <= 1'b1;
          end
        end
        if (push_c) wr_ptr <= wr_ptr + AW'(1);
        rd_ptr      <= rd_next_c;
        cnt         <= cnt_next_c;
        cmd_valid_q <= (cnt_next_c != '0);
        cmd_q       <= (cnt_next_c != '0) ? head_next_c : 3'd0;
        if (drop_c) overflow_q <= 1'b1;
      end
    end
  end

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd       = cmd_q;
  assign bus.count     = cnt;
  assign bus.overflow  = overflow_q;
endmodule
